// File: rtl/exe_fwd_hazard_ctrl_if.sv
// Operand-sourcing control bus between the ID stage and the EXE forwarding/hazard controller.
// The ID side (master) presents the decoded instruction and pipeline controls; the controller
// (slave) returns the stall request, the registered EXE mux selects and the stall counter.
interface exe_fwd_hazard_ctrl_if #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) ();
    logic             freeze;
    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_src1_en;
    logic             id_src2_en;
    logic [REG_W-1:0] id_dest;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             hazard;
    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output freeze, flush, id_valid, id_src1, id_src2, id_src1_en, id_src2_en,
               id_dest, id_wb_en, id_mem_r_en,
        input  hazard, sel_src1, sel_src2, stall_cnt
    );

    modport slave (
        input  freeze, flush, id_valid, id_src1, id_src2, id_src1_en, id_src2_en,
               id_dest, id_wb_en, id_mem_r_en,
        output hazard, sel_src1, sel_src2, stall_cnt
    );
endinterface

// File: rtl/exe_fwd_hazard_ctrl.sv
// EXE-stage operand forwarding and hazard control.
// Shadows dest/wb/load of the instructions in EXE and MEM, computes the operand-mux selects
// one cycle early (while the consumer is in ID) and raises a stall on load-use, or on any RAW
// hazard when forwarding is disabled. Also counts stall cycles with saturation.
module exe_fwd_hazard_ctrl #(
    parameter int unsigned REG_W  = 4,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    exe_fwd_hazard_ctrl_if.slave bus
);

    // Shadow pipeline slots. The MEM slot needs no load flag: a load in MEM is forwardable.
    logic [REG_W-1:0] exe_dest_q, mem_dest_q;
    logic             exe_wb_q, mem_wb_q;
    logic             exe_mem_r_q;

    logic [1:0]       sel_src1_q, sel_src1_d;
    logic [1:0]       sel_src2_q, sel_src2_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic m_exe1, m_exe2, m_mem1, m_mem2;
    logic raw_stall;
    logic hazard;
    logic take_bubble;

    // Source/producer matches of the ID instruction against the EXE and MEM slots
    always_comb begin
        m_exe1 = bus.id_valid & bus.id_src1_en & exe_wb_q & (exe_dest_q == bus.id_src1);
        m_exe2 = bus.id_valid & bus.id_src2_en & exe_wb_q & (exe_dest_q == bus.id_src2);
        m_mem1 = bus.id_valid & bus.id_src1_en & mem_wb_q & (mem_dest_q == bus.id_src1);
        m_mem2 = bus.id_valid & bus.id_src2_en & mem_wb_q & (mem_dest_q == bus.id_src2);
    end

    // Stall request; a squashed ID instruction never stalls
    always_comb begin
        if (FWD_EN) begin
            raw_stall = (m_exe1 | m_exe2) & exe_mem_r_q;
        end else begin
            raw_stall = m_exe1 | m_exe2 | m_mem1 | m_mem2;
        end
        hazard      = raw_stall & ~bus.flush;
        take_bubble = hazard | bus.flush | ~bus.id_valid;
    end

    // Next operand selects: the newer producer (EXE, moving to MEM) wins over MEM (moving to WB)
    always_comb begin
        sel_src1_d = 2'b00;
        sel_src2_d = 2'b00;
        if (FWD_EN && !take_bubble) begin
            if (m_exe1) begin
                sel_src1_d = 2'b01;
            end else if (m_mem1) begin
                sel_src1_d = 2'b10;
            end
            if (m_exe2) begin
                sel_src2_d = 2'b01;
            end else if (m_mem2) begin
                sel_src2_d = 2'b10;
            end
        end
    end

    // Shadow pipeline advance: EXE moves to MEM, ID (or a bubble) moves to EXE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_dest_q  <= '0;
            exe_wb_q    <= 1'b0;
            exe_mem_r_q <= 1'b0;
            mem_dest_q  <= '0;
            mem_wb_q    <= 1'b0;
        end else if (!bus.freeze) begin
            mem_dest_q <= exe_dest_q;
            mem_wb_q   <= exe_wb_q;
            if (take_bubble) begin
                exe_dest_q  <= '0;
                exe_wb_q    <= 1'b0;
                exe_mem_r_q <= 1'b0;
            end else begin
                exe_dest_q  <= bus.id_dest;
                exe_wb_q    <= bus.id_wb_en;
                exe_mem_r_q <= bus.id_mem_r_en;
            end
        end
    end

    // Selects registered so they line up with the cycle the consumer sits in EXE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_src1_q <= 2'b00;
            sel_src2_q <= 2'b00;
        end else if (!bus.freeze) begin
            sel_src1_q <= sel_src1_d;
            sel_src2_q <= sel_src2_d;
        end
    end

    // Saturating count of unfrozen stall cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (!bus.freeze && hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.hazard    = hazard;
    assign bus.sel_src1  = sel_src1_q;
    assign bus.sel_src2  = sel_src2_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exe_fwd_hazard_ctrl.sv
// Bench for exe_fwd_hazard_ctrl: three instances (forwarding, no forwarding, 4-bit counter)
// share one ID stimulus stream and are compared against a pipeline model every cycle,
// plus hand-derived vector table and corner-case sequences.
module tb_exe_fwd_hazard_ctrl;

    logic clk;
    logic rst;

    logic       freeze, flush, id_valid;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_src1_en, id_src2_en, id_wb_en, id_mem_r_en;

    exe_fwd_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) if_f ();
    exe_fwd_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) if_n ();
    exe_fwd_hazard_ctrl_if #(.REG_W(4), .CNT_W(4))  if_s ();

    assign if_f.freeze = freeze;           assign if_n.freeze = freeze;           assign if_s.freeze = freeze;
    assign if_f.flush = flush;             assign if_n.flush = flush;             assign if_s.flush = flush;
    assign if_f.id_valid = id_valid;       assign if_n.id_valid = id_valid;       assign if_s.id_valid = id_valid;
    assign if_f.id_src1 = id_src1;         assign if_n.id_src1 = id_src1;         assign if_s.id_src1 = id_src1;
    assign if_f.id_src2 = id_src2;         assign if_n.id_src2 = id_src2;         assign if_s.id_src2 = id_src2;
    assign if_f.id_src1_en = id_src1_en;   assign if_n.id_src1_en = id_src1_en;   assign if_s.id_src1_en = id_src1_en;
    assign if_f.id_src2_en = id_src2_en;   assign if_n.id_src2_en = id_src2_en;   assign if_s.id_src2_en = id_src2_en;
    assign if_f.id_dest = id_dest;         assign if_n.id_dest = id_dest;         assign if_s.id_dest = id_dest;
    assign if_f.id_wb_en = id_wb_en;       assign if_n.id_wb_en = id_wb_en;       assign if_s.id_wb_en = id_wb_en;
    assign if_f.id_mem_r_en = id_mem_r_en; assign if_n.id_mem_r_en = id_mem_r_en; assign if_s.id_mem_r_en = id_mem_r_en;

    exe_fwd_hazard_ctrl #(.REG_W(4), .FWD_EN(1'b1), .CNT_W(16)) dut_f (
        .clk (clk), .rst (rst), .bus (if_f)
    );
    exe_fwd_hazard_ctrl #(.REG_W(4), .FWD_EN(1'b0), .CNT_W(16)) dut_n (
        .clk (clk), .rst (rst), .bus (if_n)
    );
    exe_fwd_hazard_ctrl #(.REG_W(4), .FWD_EN(1'b1), .CNT_W(4)) dut_s (
        .clk (clk), .rst (rst), .bus (if_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // An in-flight instruction: which register it produces and whether its value is late (load).
    typedef struct {
        bit writes;
        int dest;
        bit is_load;
    } inflight_t;

    inflight_t in_exe [3];
    inflight_t in_mem [3];
    int        m_sel1 [3];
    int        m_sel2 [3];
    int        m_cnt  [3];
    bit        fwd_of [3] = '{1'b1, 1'b0, 1'b1};
    int        cmax   [3] = '{65535, 65535, 15};

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            in_exe[k] = '{1'b0, 0, 1'b0};
            in_mem[k] = '{1'b0, 0, 1'b0};
            m_sel1[k] = 0;
            m_sel2[k] = 0;
            m_cnt[k]  = 0;
        end
    endfunction

    // Where the youngest producer of register r currently is: 1 = EXE, 2 = MEM, 0 = none/WB.
    function automatic int producer_of(int k, int r);
        if (in_exe[k].writes && in_exe[k].dest == r) return 1;
        if (in_mem[k].writes && in_mem[k].dest == r) return 2;
        return 0;
    endfunction

    function automatic bit source_stalls(int k, bit en, int r);
        int p;
        if (!en) return 1'b0;
        p = producer_of(k, r);
        if (fwd_of[k]) return (p == 1) && in_exe[k].is_load;
        return p != 0;
    endfunction

    function automatic bit model_hazard(int k);
        if (flush || !id_valid) return 1'b0;
        return source_stalls(k, id_src1_en, int'(id_src1)) ||
               source_stalls(k, id_src2_en, int'(id_src2));
    endfunction

    function automatic void model_clock();
        bit hz, accept;
        int s1, s2;
        if (freeze) return;
        for (int k = 0; k < 3; k++) begin
            hz     = model_hazard(k);
            accept = !(hz || flush || !id_valid);
            s1 = (accept && fwd_of[k] && id_src1_en) ? producer_of(k, int'(id_src1)) : 0;
            s2 = (accept && fwd_of[k] && id_src2_en) ? producer_of(k, int'(id_src2)) : 0;
            in_mem[k] = in_exe[k];
            if (accept) in_exe[k] = '{bit'(id_wb_en), int'(id_dest), bit'(id_mem_r_en)};
            else        in_exe[k] = '{1'b0, 0, 1'b0};
            m_sel1[k] = s1;
            m_sel2[k] = s2;
            if (hz && m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void get_dut(input int k, output int hz, output int s1, output int s2,
                                    output int cnt);
        case (k)
            0: begin hz = int'(if_f.hazard); s1 = int'(if_f.sel_src1);
                     s2 = int'(if_f.sel_src2); cnt = int'(if_f.stall_cnt); end
            1: begin hz = int'(if_n.hazard); s1 = int'(if_n.sel_src1);
                     s2 = int'(if_n.sel_src2); cnt = int'(if_n.stall_cnt); end
            default: begin hz = int'(if_s.hazard); s1 = int'(if_s.sel_src1);
                     s2 = int'(if_s.sel_src2); cnt = int'(if_s.stall_cnt); end
        endcase
    endfunction

    task automatic sample();
        int hz, s1, s2, cnt;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            get_dut(k, hz, s1, s2, cnt);
            chk($sformatf("model hazard[%0d]", k), hz, int'(model_hazard(k)));
            chk($sformatf("model sel_src1[%0d]", k), s1, m_sel1[k]);
            chk($sformatf("model sel_src2[%0d]", k), s2, m_sel2[k]);
            chk($sformatf("model stall_cnt[%0d]", k), cnt, m_cnt[k]);
        end
    endtask

    task automatic advance();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int v, input int s1, input int e1, input int s2, input int e2,
                          input int d, input int wb, input int ld);
        id_valid    = 1'(v);
        id_src1     = 4'(s1);
        id_src1_en  = 1'(e1);
        id_src2     = 4'(s2);
        id_src2_en  = 1'(e2);
        id_dest     = 4'(d);
        id_wb_en    = 1'(wb);
        id_mem_r_en = 1'(ld);
        freeze      = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        int hz, s1, s2, cnt;
        for (int k = 0; k < 3; k++) begin
            get_dut(k, hz, s1, s2, cnt);
            chk($sformatf("%s hazard[%0d]", tag, k), hz, 0);
            chk($sformatf("%s sel_src1[%0d]", tag, k), s1, 0);
            chk($sformatf("%s sel_src2[%0d]", tag, k), s2, 0);
            chk($sformatf("%s stall_cnt[%0d]", tag, k), cnt, 0);
        end
    endtask

    // Vector table for the forwarding instance: ID inputs and what must be seen that cycle.
    typedef struct {
        int v, s1, e1, s2, e2, d, wb, ld;
        int hz, x1, x2, cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int hz, s1, s2, cnt;

        //          v s1 e1 s2 e2 d wb ld   hz x1 x2 cnt
        tbl[0]  = '{1, 2, 1, 3, 1, 1, 1, 0,  0, 0, 0, 0};  // ADD r1,r2,r3
        tbl[1]  = '{1, 1, 1, 3, 1, 2, 1, 0,  0, 0, 0, 0};  // ADD r2,r1,r3
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0};  // NOP; r2 add forwards from MEM
        tbl[3]  = '{1, 4, 1, 5, 1, 1, 1, 0,  0, 0, 0, 0};  // ADD r1,r4,r5
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};  // NOP
        tbl[5]  = '{1, 5, 1, 1, 1, 4, 1, 0,  0, 0, 0, 0};  // SUB r4,r5,r1
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0};  // NOP; SUB takes r1 from WB
        tbl[7]  = '{1, 2, 1, 0, 0, 6, 1, 1,  0, 0, 0, 0};  // LDR r6,[r2]
        tbl[8]  = '{1, 6, 1, 6, 1, 7, 1, 0,  1, 0, 0, 0};  // ADD r7,r6,r6 -> load-use
        tbl[9]  = '{1, 6, 1, 6, 1, 7, 1, 0,  0, 0, 0, 1};  // held ADD, bubble in EXE
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 2, 1};  // ADD in EXE, both from WB
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1};

        // Reset state
        rst = 1'b0;
        nop();
        model_reset();
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Back-to-back forwarding, forwarding from WB, load-use stall
        for (int i = 0; i < 12; i++) begin
            set_id(tbl[i].v, tbl[i].s1, tbl[i].e1, tbl[i].s2, tbl[i].e2,
                   tbl[i].d, tbl[i].wb, tbl[i].ld);
            sample();
            get_dut(0, hz, s1, s2, cnt);
            chk($sformatf("vec%0d hazard", i), hz, tbl[i].hz);
            chk($sformatf("vec%0d sel_src1", i), s1, tbl[i].x1);
            chk($sformatf("vec%0d sel_src2", i), s2, tbl[i].x2);
            chk($sformatf("vec%0d stall_cnt", i), cnt, tbl[i].cnt);
            advance();
        end

        // Load-use stall with freeze held for three cycles: nothing moves, counted once
        set_id(1, 2, 1, 0, 0, 6, 1, 1);
        sample();
        advance();
        for (int i = 0; i < 3; i++) begin
            set_id(1, 6, 1, 6, 1, 7, 1, 0);
            freeze = 1'b1;
            sample();
            get_dut(0, hz, s1, s2, cnt);
            chk("frozen hazard", hz, 1);
            chk("frozen stall_cnt", cnt, 1);
            chk("frozen sel_src1", s1, 0);
            advance();
        end
        set_id(1, 6, 1, 6, 1, 7, 1, 0);
        sample();
        get_dut(0, hz, s1, s2, cnt);
        chk("unfrozen hazard", hz, 1);
        advance();
        set_id(1, 6, 1, 6, 1, 7, 1, 0);
        sample();
        get_dut(0, hz, s1, s2, cnt);
        chk("after freeze hazard", hz, 0);
        chk("after freeze stall_cnt", cnt, 2);
        advance();
        nop();
        sample();
        get_dut(0, hz, s1, s2, cnt);
        chk("after freeze sel_src1", s1, 2);
        chk("after freeze sel_src2", s2, 2);
        advance();

        // No-forwarding instance: two-cycle RAW stall, then flush overriding a hazard
        nop(); sample(); advance();
        nop(); sample(); advance();
        set_id(1, 4, 1, 5, 1, 1, 1, 0);
        sample(); advance();
        for (int i = 0; i < 3; i++) begin
            set_id(1, 1, 1, 1, 1, 2, 1, 0);
            sample();
            get_dut(1, hz, s1, s2, cnt);
            chk($sformatf("nofwd raw%0d hazard", i), hz, (i < 2) ? 1 : 0);
            chk($sformatf("nofwd raw%0d sel_src1", i), s1, 0);
            advance();
        end
        set_id(1, 4, 1, 5, 1, 1, 1, 0);
        sample(); advance();
        set_id(1, 1, 1, 1, 1, 2, 1, 0);
        flush = 1'b1;
        sample();
        get_dut(1, hz, s1, s2, cnt);
        chk("nofwd flush hazard", hz, 0);
        advance();
        set_id(1, 2, 1, 2, 1, 3, 1, 0);
        sample();
        get_dut(1, hz, s1, s2, cnt);
        chk("nofwd flushed bubble hazard", hz, 0);
        get_dut(0, hz, s1, s2, cnt);
        chk("fwd flushed bubble sel_src1", s1, 0);
        advance();
        nop(); sample(); advance();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_id(($urandom % 10) < 8 ? 1 : 0, $urandom % 4, $urandom % 2, $urandom % 4,
                   $urandom % 2, $urandom % 4, ($urandom % 4) != 0 ? 1 : 0,
                   ($urandom % 3) == 0 ? 1 : 0);
            freeze = 1'(($urandom % 10) == 0);
            flush  = 1'(($urandom % 10) == 0);
            sample();
            advance();
        end

        // Counter saturation, then asynchronous reset in the middle of a stall
        nop();
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset2");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_id(1, 2, 1, 0, 0, 6, 1, 1);
            sample(); advance();
            set_id(1, 6, 1, 6, 1, 7, 1, 0);
            sample(); advance();
            sample(); advance();
        end
        set_id(1, 2, 1, 0, 0, 6, 1, 1);
        sample();
        get_dut(2, hz, s1, s2, cnt);
        chk("saturated stall_cnt", cnt, 15);
        get_dut(0, hz, s1, s2, cnt);
        chk("wide stall_cnt", cnt, 20);
        advance();
        set_id(1, 6, 1, 6, 1, 7, 1, 0);
        sample();
        get_dut(2, hz, s1, s2, cnt);
        chk("saturated stall hazard", hz, 1);
        advance();
        set_id(1, 2, 1, 0, 0, 6, 1, 1);
        sample(); advance();
        set_id(1, 6, 1, 6, 1, 7, 1, 0);
        sample();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("midstall reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_id(1, 6, 1, 6, 1, 7, 1, 0);
        sample();
        get_dut(0, hz, s1, s2, cnt);
        chk("post reset hazard", hz, 0);
        advance();
        nop();
        sample();
        get_dut(0, hz, s1, s2, cnt);
        chk("post reset sel_src1", s1, 0);
        advance();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
